mem_line_bridge: RTL and testbench

- Sits directly downstream of the data-cache controller's memory interface.
- Accepts single-cycle 64-bit cache-line requests (write-back or allocate-read) and runs each as a two-beat transfer on a 32-bit word-wide memory bus.
- Returns a single-cycle ready pulse. For reads, the pulse carries the assembled 64-bit line.

---
 rtl/mem_line_bridge_pkg.sv | 34 +++
 rtl/mem_line_bridge_if.sv | 35 +++
 rtl/mem_line_buffer.sv | 30 +++
 rtl/mem_line_bridge.sv | 164 ++++++++++++++++
 tb/tb_mem_line_bridge.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_bridge_pkg.sv
// Shared cache-line types and constants for the memory line bridge.
// Holds the line/word geometry, request/response structs and the bridge state enum.
package mem_line_bridge_pkg;

  localparam int unsigned LINE_W       = 64;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned WORD_SEL_BIT = 2;
  localparam int unsigned LINE_OFF_W   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBeat0 = 2'd1,
    StBeat1 = 2'd2,
    StResp  = 2'd3
  } bridge_state_e;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [LINE_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic              ready;
    logic              err;
    logic [LINE_W-1:0] data;
  } mem_res_t;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic              sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/mem_line_bridge_if.sv
// Cache-controller and word-bus signal bundle for the memory line bridge.
// The slave modport is the bridge; the master modport is its environment.
interface mem_line_bridge_if #(
  parameter int unsigned ADDR_W = 32
);
  import mem_line_bridge_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_res_ready;
  logic [LINE_W-1:0] mem_res_data;
  logic              mem_res_err;
  logic              busy;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [WORD_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [WORD_W-1:0] bus_rdata;

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, bus_ack, bus_rdata,
    output mem_res_ready, mem_res_data, mem_res_err, busy, bus_req, bus_we, bus_addr,
           bus_wdata
  );

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, bus_ack, bus_rdata,
    input  mem_res_ready, mem_res_data, mem_res_err, busy, bus_req, bus_we, bus_addr,
           bus_wdata
  );

endinterface

// File: rtl/mem_line_buffer.sv
// 64-bit line register with a full-line load and per-word load enables.
// A full-line load takes priority over word loads in the same cycle.
module mem_line_buffer
  import mem_line_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              line_load,
  input  logic [LINE_W-1:0] line_data,
  input  logic [1:0]        word_load,
  input  logic [WORD_W-1:0] word_data,
  output logic [LINE_W-1:0] line
);

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_q <= '0;
    end else if (line_load) begin
      line_q <= line_data;
    end else begin
      if (word_load[0]) line_q[WORD_W-1:0]      <= word_data;
      if (word_load[1]) line_q[LINE_W-1:WORD_W] <= word_data;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/mem_line_bridge.sv
// Runs each 64-bit cache-line request as two 32-bit beats on the word bus.
// Optional bus-ack timeout is compiled in with MEM_LINE_BRIDGE_TIMEOUT_EN.
module mem_line_bridge
  import mem_line_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BUS_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  mem_line_bridge_if.slave   br
);

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              rw_q, rw_d;
  logic              err_q, err_d;
  logic              timeout_hit;
  logic              beat;

  mem_req_t          req;
  mem_res_t          res;

  logic              line_load;
  logic [LINE_W-1:0] line_data;
  logic [1:0]        word_load;
  logic [WORD_W-1:0] word_data;
  logic [LINE_W-1:0] line_q;

  logic              unused_addr_bits;

  assign req.valid = br.mem_req_valid;
  assign req.rw    = br.mem_req_rw;
  assign req.data  = br.mem_req_data;
  assign unused_addr_bits = ^br.mem_req_addr[LINE_OFF_W-1:0];

  assign beat = (state_q == StBeat1);

  mem_line_buffer u_line_buffer (
    .clk       (clk),
    .n_rst     (n_rst),
    .line_load (line_load),
    .line_data (line_data),
    .word_load (word_load),
    .word_data (word_data),
    .line      (line_q)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    rw_d         = rw_q;
    err_d        = err_q;
    line_load    = 1'b0;
    line_data    = req.data;
    word_load    = 2'b00;
    word_data    = br.bus_rdata;
    br.bus_req   = 1'b0;
    br.bus_we    = 1'b0;
    br.bus_addr  = '0;
    br.bus_wdata = '0;
    res          = '0;

    unique case (state_q)
      StIdle: begin
        if (req.valid) begin
          base_d    = {br.mem_req_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          rw_d      = req.rw;
          err_d     = 1'b0;
          line_load = 1'b1;
          state_d   = StBeat0;
        end
      end
      StBeat0, StBeat1: begin
        br.bus_req   = 1'b1;
        br.bus_we    = rw_q;
        // base has zero offset bits, so OR-ing in the word select is the +4
        br.bus_addr  = base_q | {{(ADDR_W-LINE_OFF_W){1'b0}}, beat, {WORD_SEL_BIT{1'b0}}};
        br.bus_wdata = line_word(line_q, beat);
        if (br.bus_ack) begin
          if (!rw_q) word_load[beat] = 1'b1;
          state_d = beat ? StResp : StBeat1;
        end else if (timeout_hit) begin
          if (beat) begin
            word_load[1] = 1'b1;
            word_data    = '0;
          end else begin
            line_load = 1'b1;
            line_data = '0;
          end
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        res.ready = 1'b1;
        res.err   = err_q;
        res.data  = line_q;
        // Chained request (write-back then allocate) skips the idle cycle
        if (req.valid) begin
          base_d    = {br.mem_req_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          rw_d      = req.rw;
          err_d     = 1'b0;
          line_load = 1'b1;
          state_d   = StBeat0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rw_q    <= rw_d;
    end
  end

`ifdef MEM_LINE_BRIDGE_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(BUS_TIMEOUT) + 1;

  logic [TimerW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == StBeat0 || state_q == StBeat1) && !br.bus_ack) begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign timeout_hit = (timer_q == TimerW'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
  assign unused_cfg  = ^{BUS_TIMEOUT, err_d};
`endif

  assign br.mem_res_ready = res.ready;
  assign br.mem_res_err   = res.err;
  assign br.mem_res_data  = res.data;
  assign br.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge: a vector table of zero-wait line transfers
// plus hand-written wait-state, chaining, protocol-violation and reset sequences.
module tb_mem_line_bridge;

  logic clk;
  logic n_rst;

  int errors = 0;
  int checks = 0;
  string phase;

  mem_line_bridge_if #(.ADDR_W(32)) bif ();

  mem_line_bridge #(
    .ADDR_W      (32),
    .BUS_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .br    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.mem_req_valid = 1'b0;
    bif.mem_req_rw    = 1'b0;
    bif.mem_req_addr  = 32'h0;
    bif.mem_req_data  = 64'h0;
    bif.bus_ack       = 1'b0;
    bif.bus_rdata     = 32'h0;
  endtask

  // Zero-wait transfer: request, BEAT0, BEAT1, RESP, back to idle
  task automatic run_txn(input vec_t v);
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = v.rw;
    bif.mem_req_addr  = v.addr;
    bif.mem_req_data  = v.wdata;
    chk("idle_busy", bif.busy, 0);
    step();
    bif.mem_req_valid = 1'b0;
    chk("b0_req", bif.bus_req, 1);
    chk("b0_addr", bif.bus_addr, v.a0);
    chk("b0_we", bif.bus_we, v.rw);
    chk("b0_ready", bif.mem_res_ready, 0);
    if (v.rw) chk("b0_wdata", bif.bus_wdata, v.w0);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = v.rd0;
    step();
    chk("b1_addr", bif.bus_addr, v.a1);
    chk("b1_we", bif.bus_we, v.rw);
    if (v.rw) chk("b1_wdata", bif.bus_wdata, v.w1);
    bif.bus_rdata = v.rd1;
    step();
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'h0;
    chk("resp_ready", bif.mem_res_ready, 1);
    chk("resp_data", bif.mem_res_data, v.exp);
    chk("resp_err", bif.mem_res_err, 0);
    chk("resp_busreq", bif.bus_req, 0);
    step();
    chk("done_ready", bif.mem_res_ready, 0);
    chk("done_busy", bif.busy, 0);
  endtask

  initial begin
    vecs[0] = '{rw: 1'b0, addr: 32'h0000_1008, wdata: 64'h0, rd0: 32'hAAAA_0001,
                rd1: 32'hBBBB_0002, a0: 32'h0000_1008, a1: 32'h0000_100C, w0: 32'h0,
                w1: 32'h0, exp: 64'hBBBB_0002_AAAA_0001};
    vecs[1] = '{rw: 1'b0, addr: 32'h0005_FFFF, wdata: 64'hFFFF_FFFF_FFFF_FFFF,
                rd0: 32'h1234_5678, rd1: 32'h9ABC_DEF0, a0: 32'h0005_FFF8,
                a1: 32'h0005_FFFC, w0: 32'h0, w1: 32'h0, exp: 64'h9ABC_DEF0_1234_5678};
    vecs[2] = '{rw: 1'b1, addr: 32'hFFFF_FFFC, wdata: 64'hDEAD_BEEF_CAFE_F00D,
                rd0: 32'hFFFF_FFFF, rd1: 32'hFFFF_FFFF, a0: 32'hFFFF_FFF8,
                a1: 32'hFFFF_FFFC, w0: 32'hCAFE_F00D, w1: 32'hDEAD_BEEF,
                exp: 64'hDEAD_BEEF_CAFE_F00D};
    vecs[3] = '{rw: 1'b1, addr: 32'h0000_0007, wdata: 64'h0123_4567_89AB_CDEF,
                rd0: 32'h5A5A_5A5A, rd1: 32'hA5A5_A5A5, a0: 32'h0000_0000,
                a1: 32'h0000_0004, w0: 32'h89AB_CDEF, w1: 32'h0123_4567,
                exp: 64'h0123_4567_89AB_CDEF};

    idle_inputs();
    n_rst = 1'b0;
    phase = "reset";
    #12;
    chk("ready", bif.mem_res_ready, 0);
    chk("data", bif.mem_res_data, 64'h0);
    chk("err", bif.mem_res_err, 0);
    chk("busy", bif.busy, 0);
    chk("bus_req", bif.bus_req, 0);
    chk("bus_we", bif.bus_we, 0);
    chk("bus_addr", bif.bus_addr, 32'h0);
    chk("bus_wdata", bif.bus_wdata, 32'h0);
    step();
    n_rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      phase = $sformatf("vec%0d", i);
      run_txn(vecs[i]);
    end

    // Write with three wait cycles per beat
    phase = "wait_write";
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = 1'b1;
    bif.mem_req_addr  = 32'h0000_2004;
    bif.mem_req_data  = 64'h1111_2222_3333_4444;
    step();
    bif.mem_req_valid = 1'b0;
    bif.mem_req_data  = 64'h0;
    for (int w = 0; w < 3; w++) begin
      chk("b0_req", bif.bus_req, 1);
      chk("b0_addr", bif.bus_addr, 32'h0000_2000);
      chk("b0_wdata", bif.bus_wdata, 32'h3333_4444);
      chk("b0_we", bif.bus_we, 1);
      chk("b0_ready", bif.mem_res_ready, 0);
      step();
    end
    chk("b0_addr_ack", bif.bus_addr, 32'h0000_2000);
    bif.bus_ack = 1'b1;
    step();
    bif.bus_ack = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("b1_req", bif.bus_req, 1);
      chk("b1_addr", bif.bus_addr, 32'h0000_2004);
      chk("b1_wdata", bif.bus_wdata, 32'h1111_2222);
      chk("b1_ready", bif.mem_res_ready, 0);
      step();
    end
    bif.bus_ack = 1'b1;
    step();
    bif.bus_ack = 1'b0;
    chk("resp_ready", bif.mem_res_ready, 1);
    chk("resp_data", bif.mem_res_data, 64'h1111_2222_3333_4444);
    step();
    chk("single_pulse", bif.mem_res_ready, 0);
    chk("idle_busy", bif.busy, 0);

    // Write-back chained into an allocate read in the RESP cycle
    phase = "chain";
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = 1'b1;
    bif.mem_req_addr  = 32'h0000_3000;
    bif.mem_req_data  = 64'h5555_6666_7777_8888;
    step();
    bif.mem_req_valid = 1'b0;
    bif.bus_ack       = 1'b1;
    chk("wb_b0_addr", bif.bus_addr, 32'h0000_3000);
    step();
    chk("wb_b1_wdata", bif.bus_wdata, 32'h5555_6666);
    step();
    bif.bus_ack       = 1'b0;
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = 1'b0;
    bif.mem_req_addr  = 32'h0000_4000;
    bif.mem_req_data  = 64'h0;
    chk("wb_ready", bif.mem_res_ready, 1);
    chk("wb_data", bif.mem_res_data, 64'h5555_6666_7777_8888);
    step();
    bif.mem_req_valid = 1'b0;
    chk("rd_busy", bif.busy, 1);
    chk("rd_b0_req", bif.bus_req, 1);
    chk("rd_b0_addr", bif.bus_addr, 32'h0000_4000);
    chk("rd_b0_we", bif.bus_we, 0);
    chk("rd_b0_ready", bif.mem_res_ready, 0);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h0BAD_0001;
    step();
    chk("rd_b1_addr", bif.bus_addr, 32'h0000_4004);
    bif.bus_rdata = 32'h0BAD_0002;
    step();
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'h0;
    chk("rd_ready", bif.mem_res_ready, 1);
    chk("rd_data", bif.mem_res_data, 64'h0BAD_0002_0BAD_0001);
    step();
    chk("rd_done", bif.mem_res_ready, 0);

    // Stray request during BEAT1 must be ignored
    phase = "stray";
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = 1'b0;
    bif.mem_req_addr  = 32'h0000_6000;
    step();
    bif.mem_req_valid = 1'b0;
    bif.bus_ack       = 1'b1;
    bif.bus_rdata     = 32'hC0DE_0001;
    step();
    bif.bus_ack       = 1'b0;
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = 1'b1;
    bif.mem_req_addr  = 32'h0000_7000;
    bif.mem_req_data  = 64'hEEEE_EEEE_EEEE_EEEE;
    step();
    bif.mem_req_valid = 1'b0;
    chk("b1_addr", bif.bus_addr, 32'h0000_6004);
    chk("b1_we", bif.bus_we, 0);
    chk("b1_busy", bif.busy, 1);
    chk("b1_ready", bif.mem_res_ready, 0);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'hC0DE_0002;
    step();
    bif.bus_ack = 1'b0;
    chk("resp_ready", bif.mem_res_ready, 1);
    chk("resp_busy", bif.busy, 1);
    chk("resp_data", bif.mem_res_data, 64'hC0DE_0002_C0DE_0001);
    step();
    chk("after_ready", bif.mem_res_ready, 0);
    chk("after_busy", bif.busy, 0);
    step();
    chk("no_second", bif.mem_res_ready, 0);

    // Asynchronous reset in BEAT0
    phase = "midreset";
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = 1'b0;
    bif.mem_req_addr  = 32'h0000_8000;
    step();
    bif.mem_req_valid = 1'b0;
    chk("b0_req", bif.bus_req, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_busreq", bif.bus_req, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_ready", bif.mem_res_ready, 0);
    step();
    step();
    chk("held_ready", bif.mem_res_ready, 0);
    n_rst = 1'b1;
    step();
    chk("post_busy", bif.busy, 0);
    phase = "post_reset_read";
    run_txn(vecs[0]);

    // Bus never acknowledges
    phase = "no_ack";
    bif.mem_req_valid = 1'b1;
    bif.mem_req_rw    = 1'b0;
    bif.mem_req_addr  = 32'h0000_9000;
    step();
    bif.mem_req_valid = 1'b0;
`ifdef MEM_LINE_BRIDGE_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      chk("to_req", bif.bus_req, 1);
      step();
    end
    chk("to_req_drop", bif.bus_req, 0);
    chk("to_ready", bif.mem_res_ready, 1);
    chk("to_err", bif.mem_res_err, 1);
    chk("to_data", bif.mem_res_data, 64'h0);
    step();
    chk("to_idle", bif.busy, 0);
`else
    for (int c = 0; c < 80; c++) begin
      chk("hang_busy", bif.busy, 1);
      chk("hang_ready", bif.mem_res_ready, 0);
      step();
    end
    chk("hang_req", bif.bus_req, 1);
    chk("hang_err", bif.mem_res_err, 0);
`endif
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
